pc_fetch_unit: RTL and testbench

- Consumer of the next-PC computation and owner of the architectural fetch PC.
- Holds the PC and issues sequential instruction fetches over a valid/ready request port to instruction memory. Returned words are buffered in a small FIFO and presented to decode with their PC.
- Accepts redirect targets (branch/jump/JR results in word-address form [31:2]), flushes wrong-path state, and discards stale in-flight responses.

---
 rtl/pc_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_fetch_unit : fetch PC owner, imem request port, response FIFO, redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds stall/drop counters.        Rev 1.0
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_drop_cnt,
`endif
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int TPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW  = ((OW > CW) ? OW : CW) + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [29:0]     pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [FPW-1:0]  fifo_rd;
  logic [FPW-1:0]  fifo_wr;
  logic [TPW-1:0]  tag_rd;
  logic [TPW-1:0]  tag_wr;
  logic [31:0]     fifo_data [FIFO_DEPTH];
  logic [29:0]     fifo_pc   [FIFO_DEPTH];
  logic [29:0]     tag_pc    [MAX_OUTST];

  logic            fire_req;
  logic            push;
  logic            pop;
  logic [SW-1:0]   inflight;
  logic [OW:0]     discard_sum;

  function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request gating only looks at registered state so req_valid never depends on same-cycle inputs.
  assign inflight    = SW'(outst) + SW'(fifo_count);
  assign req_valid   = (state == FETCH) && (inflight < SW'(FIFO_DEPTH)) && (outst < OW'(MAX_OUTST));
  assign req_addr    = {pc, 2'b00};
  assign fire_req    = req_valid & req_ready;
  assign push        = resp_valid & (state == FETCH) & ~redirect_valid;
  assign inst_valid  = (fifo_count != '0);
  assign pop         = inst_valid & inst_ready;
  assign inst        = inst_valid ? fifo_data[fifo_rd] : '0;
  assign inst_pc     = inst_valid ? {fifo_pc[fifo_rd], 2'b00} : '0;
  assign discard_sum = {1'b0, discard} + {1'b0, outst} + (OW+1)'(fire_req) - (OW+1)'(resp_valid);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= BOOT;
      pc         <= RESET_PC[31:2];
      outst      <= '0;
      discard    <= '0;
      fifo_count <= '0;
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      tag_rd     <= '0;
      tag_wr     <= '0;
    end else begin
      if (fire_req) begin
        pc     <= pc + 30'd1;
        tag_wr <= tag_next(tag_wr);
      end
      if (push) begin
        fifo_wr <= fifo_wr + 1'b1;
        tag_rd  <= tag_next(tag_rd);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (fire_req && !push) begin
        outst <= outst + 1'b1;
      end else if (push && !fire_req) begin
        outst <= outst - 1'b1;
      end
      case (state)
        BOOT:  state <= FETCH;
        FETCH: ;
        FLUSH: begin
          if (resp_valid) begin
            discard <= discard - 1'b1;
            if (discard == OW'(1)) begin
              state <= FETCH;
            end
          end
        end
        default: state <= BOOT;
      endcase
      // Redirect wins: every in-flight request becomes a response to drop.
      if (redirect_valid) begin
        pc         <= redirect_pc;
        fifo_count <= '0;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        tag_rd     <= '0;
        tag_wr     <= '0;
        if (state != BOOT) begin
          outst   <= '0;
          discard <= discard_sum[OW-1:0];
          state   <= (discard_sum != '0) ? FLUSH : FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wr] <= resp_data;
      fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
    end
    if (fire_req) begin
      tag_pc[tag_wr] <= pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic drop;
  assign drop = resp_valid & ~push;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (inst_valid && !inst_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (drop) begin
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_resp_tracked: assert property (@(posedge clk) disable iff (!resetn)
    resp_valid |-> (outst != '0 || discard != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit with an in-order imem model.
module tb_pc_fetch_unit;

  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] fired_q[$];
  logic [31:0] popped_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          g_req_ready = 1'b1;
  bit          g_inst_ready = 1'b1;
  bit          g_resp_en = 1'b1;
  logic [29:0] model_pc;
  int          model_discard = 0;
  int          model_fifo_cnt = 0;
  int          model_drop = 0;
  bit          hold_pending = 1'b0;
  logic [31:0] hold_addr = '0;

  pc_fetch_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_drop_cnt (perf_drop_cnt),
`endif
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // One clock cycle: drive inputs at the negedge, check, update the model, wait for next negedge.
  task automatic step(input bit redir, input logic [29:0] tgt);
    bit          resp;
    bit          fire;
    bit          pop;
    logic [31:0] raddr;
    exp_t        e;
    resp  = 1'b0;
    raddr = '0;
    if (g_resp_en && mem_q.size() > 0) begin
      raddr = mem_q.pop_front();
      resp  = 1'b1;
    end
    resp_valid     = resp;
    resp_data      = resp ? mem_word(raddr) : 32'h0;
    req_ready      = g_req_ready;
    inst_ready     = g_inst_ready;
    redirect_valid = redir;
    redirect_pc    = tgt;

    n_checks++;
    if (req_valid !== (model_discard == 0 && exp_q.size() < FIFO_DEPTH)) begin
      n_errors++;
      $display("FAIL req_gate: req_valid=%b expected=%b (discard=%0d queued=%0d)",
               req_valid, (model_discard == 0 && exp_q.size() < FIFO_DEPTH), model_discard, exp_q.size());
    end
    if (hold_pending) begin
      n_checks++;
      if (req_valid !== 1'b1 || req_addr !== hold_addr) begin
        n_errors++;
        $display("FAIL req_hold: req_valid=%b req_addr=%h expected addr %h", req_valid, req_addr, hold_addr);
      end
    end
    n_checks++;
    if (inst_valid !== (model_fifo_cnt != 0)) begin
      n_errors++;
      $display("FAIL inst_valid: got %b expected %b", inst_valid, (model_fifo_cnt != 0));
    end

    pop = (model_fifo_cnt != 0) && g_inst_ready;
    if (pop) begin
      e = exp_q.pop_front();
      n_checks++;
      if (inst_pc !== e.pc || inst !== e.data) begin
        n_errors++;
        $display("FAIL inst_out: inst_pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, e.pc, e.data);
      end
      popped_q.push_back(inst_pc);
      model_fifo_cnt--;
    end

    fire = (req_valid === 1'b1) && g_req_ready;
    if (fire) begin
      n_checks++;
      if (req_addr !== {model_pc, 2'b00}) begin
        n_errors++;
        $display("FAIL req_addr: got %h expected %h", req_addr, {model_pc, 2'b00});
      end
      mem_q.push_back(req_addr);
      fired_q.push_back(req_addr);
      e.pc   = {model_pc, 2'b00};
      e.data = mem_word({model_pc, 2'b00});
      exp_q.push_back(e);
      model_pc = model_pc + 30'd1;
    end

    if (resp) begin
      if (model_discard > 0) begin
        model_discard--;
        model_drop++;
      end else if (redir) begin
        model_drop++;
      end else begin
        model_fifo_cnt++;
      end
    end
    if (redir) begin
      exp_q.delete();
      model_fifo_cnt = 0;
      model_pc       = tgt;
      model_discard  = mem_q.size();
    end
    hold_pending = (req_valid === 1'b1) && !g_req_ready && !redir;
    hold_addr    = req_addr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    mem_q.delete();
    exp_q.delete();
    fired_q.delete();
    popped_q.delete();
    model_pc       = 30'h2FF0_0000;
    model_discard  = 0;
    model_fifo_cnt = 0;
    hold_pending   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_out: req_valid=%b inst_valid=%b inst=%h inst_pc=%h expected all zero",
               req_valid, inst_valid, inst, inst_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_stall_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_perf: stall=%0d drop=%0d expected 0 0", perf_stall_cnt, perf_drop_cnt);
    end
`endif
    resetn = 1'b1;
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL boot_req: req_valid=%b expected 0", req_valid);
    end
    @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'hBFC0_0000) begin
      n_errors++;
      $display("FAIL first_req: req_valid=%b req_addr=%h expected 1 bfc00000", req_valid, req_addr);
    end
  endtask

  task automatic test_stream();
    g_req_ready  = 1'b1;
    g_inst_ready = 1'b1;
    g_resp_en    = 1'b1;
    repeat (15) step(1'b0, '0);
    n_checks++;
    if (popped_q.size() < 3 || popped_q[0] !== 32'hBFC0_0000 || popped_q[1] !== 32'hBFC0_0004 ||
        popped_q[2] !== 32'hBFC0_0008) begin
      n_errors++;
      $display("FAIL stream_pcs: got %0d entries, first %h expected bfc00000/4/8",
               popped_q.size(), (popped_q.size() > 0) ? popped_q[0] : 32'h0);
    end
  endtask

  task automatic test_stall();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] s0;
`endif
    g_inst_ready = 1'b0;
    repeat (10) step(1'b0, '0);
    n_checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_block: req_valid=%b inst_valid=%b expected 0 1", req_valid, inst_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    s0 = perf_stall_cnt;
    repeat (5) step(1'b0, '0);
    n_checks++;
    if (perf_stall_cnt - s0 !== 32'd5) begin
      n_errors++;
      $display("FAIL perf_stall: delta=%0d expected 5", perf_stall_cnt - s0);
    end
`endif
    g_inst_ready = 1'b1;
    repeat (12) step(1'b0, '0);
  endtask

  task automatic test_redirect_flush();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] d0;
`endif
    g_req_ready  = 1'b1;
    g_inst_ready = 1'b1;
    g_resp_en    = 1'b0;
    repeat (4) step(1'b0, '0);
    n_checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_setup: req_valid=%b inst_valid=%b expected 0 0", req_valid, inst_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    d0 = perf_drop_cnt;
`endif
    step(1'b1, 30'h0000_0100);
    fired_q.delete();
    popped_q.delete();
    g_resp_en = 1'b1;
    repeat (8) step(1'b0, '0);
    n_checks++;
    if (fired_q.size() < 1 || fired_q[0] !== 32'h0000_0400 || popped_q.size() < 1 || popped_q[0] !== 32'h0000_0400) begin
      n_errors++;
      $display("FAIL flush_target: first req %h first inst_pc %h expected 00000400 00000400",
               (fired_q.size() > 0) ? fired_q[0] : 32'hX, (popped_q.size() > 0) ? popped_q[0] : 32'hX);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_drop_cnt - d0 !== 32'd2) begin
      n_errors++;
      $display("FAIL flush_drops: delta=%0d expected 2", perf_drop_cnt - d0);
    end
`endif
  endtask

  task automatic test_redirect_same_cycle();
    bit found;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] d0;
`endif
    g_req_ready  = 1'b1;
    g_inst_ready = 1'b1;
    g_resp_en    = 1'b1;
    found        = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (mem_q.size() == 1 && model_discard == 0 && req_valid === 1'b1) begin
        found = 1'b1;
      end else begin
        step(1'b0, '0);
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL same_setup: no cycle with outst=1 plus fire and response, got 0 expected 1");
    end else begin
`ifdef FETCH_PERF_CNT_EN
      d0 = perf_drop_cnt;
`endif
      step(1'b1, 30'h0000_2000);
      popped_q.delete();
      repeat (8) step(1'b0, '0);
      n_checks++;
      if (popped_q.size() < 1 || popped_q[0] !== 32'h0000_8000) begin
        n_errors++;
        $display("FAIL same_target: first inst_pc %h expected 00008000",
                 (popped_q.size() > 0) ? popped_q[0] : 32'hX);
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if (perf_drop_cnt - d0 !== 32'd2) begin
        n_errors++;
        $display("FAIL same_drops: delta=%0d expected 2", perf_drop_cnt - d0);
      end
`endif
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 30'h3FFF_FFFF);
    fired_q.delete();
    repeat (8) step(1'b0, '0);
    n_checks++;
    if (fired_q.size() < 2 || fired_q[0] !== 32'hFFFF_FFFC || fired_q[1] !== 32'h0000_0000) begin
      n_errors++;
      $display("FAIL pc_wrap: got %0d reqs, first %h second %h expected fffffffc 00000000", fired_q.size(),
               (fired_q.size() > 0) ? fired_q[0] : 32'hX, (fired_q.size() > 1) ? fired_q[1] : 32'hX);
    end
  endtask

  task automatic test_random();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] d0;
    int          m0;
    d0 = perf_drop_cnt;
    m0 = model_drop;
`endif
    for (int i = 0; i < 100; i++) begin
      g_req_ready  = ($urandom_range(0, 3) != 0);
      g_inst_ready = ($urandom_range(0, 3) != 0);
      g_resp_en    = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 11) == 0), 30'($urandom));
    end
    g_req_ready  = 1'b1;
    g_inst_ready = 1'b1;
    g_resp_en    = 1'b1;
    repeat (10) step(1'b0, '0);
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_drop_cnt - d0 !== 32'(model_drop - m0)) begin
      n_errors++;
      $display("FAIL random_drops: delta=%0d expected %0d", perf_drop_cnt - d0, model_drop - m0);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
    test_reset();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
